// File: rtl/decode_issue_buffer_pkg.sv
// Shared pipeline types for the decode-to-execute issue buffer.
// Holds the default widths, the entry record and the all-zero NOP entry.
package decode_issue_buffer_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned CTRL_WIDTH_DEF     = 16;
  localparam int unsigned DEPTH_DEF          = 2;

  // One decoded instruction as it waits for the execute stage (default widths).
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]     pc;
    logic [REG_ADDR_WIDTH_DEF-1:0] rs1Addr;
    logic [REG_ADDR_WIDTH_DEF-1:0] rs2Addr;
    logic [DATA_WIDTH_DEF-1:0]     rs1Data;
    logic [DATA_WIDTH_DEF-1:0]     rs2Data;
    logic [DATA_WIDTH_DEF-1:0]     imm;
    logic                          rdWen;
    logic [REG_ADDR_WIDTH_DEF-1:0] rdAddr;
    logic [CTRL_WIDTH_DEF-1:0]     ctrl;
    logic                          isHalt;
  } issue_entry_t;

  // Bubble presented downstream whenever the queue is empty.
  localparam issue_entry_t ISSUE_NOP = '0;

endpackage

// File: rtl/decode_issue_buffer_operand_bypass.sv
// Writeback snoop for one operand: returns wbData when the writeback port
// targets the given (nonzero) register, otherwise the supplied data.
// Ports:
//   wbWen/wbAddr/wbData  writeback port (wbWen may be pre-qualified by caller)
//   rsAddr/rsData        operand address and its current data
//   bypassData_c         selected operand data (combinational)
module decode_issue_buffer_operand_bypass #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      wbWen,
  input  logic [REG_ADDR_WIDTH-1:0] wbAddr,
  input  logic [DATA_WIDTH-1:0]     wbData,
  input  logic [REG_ADDR_WIDTH-1:0] rsAddr,
  input  logic [DATA_WIDTH-1:0]     rsData,
  output logic [DATA_WIDTH-1:0]     bypassData_c
);

  // Register 0 is hard-wired to zero, so writes to it never forward.
  always_comb begin
    bypassData_c = rsData;
    if (wbWen && (wbAddr == rsAddr) && (wbAddr != '0)) begin
      bypassData_c = wbData;
    end
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// Decode-to-execute issue buffer: DEPTH-entry in-order queue with valid/ready
// on both sides. Queued operands are kept current by snooping writeback.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_*                decoded instruction offered (valid/ready)
//   flush               discard all queued entries, clear halted
//   wb_*                writeback port snooped for operand forwarding
//   out_*               head entry (valid/ready); all-zero NOP when empty
//   count, halted       occupancy and halt-accepted flag
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned CTRL_WIDTH     = CTRL_WIDTH_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_pc,
  input  logic [REG_ADDR_WIDTH-1:0]      in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]      in_rs2_addr,
  input  logic [DATA_WIDTH-1:0]          in_rs1_data,
  input  logic [DATA_WIDTH-1:0]          in_rs2_data,
  input  logic [DATA_WIDTH-1:0]          in_imm,
  input  logic                           in_rd_wen,
  input  logic [REG_ADDR_WIDTH-1:0]      in_rd_addr,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_is_halt,
  input  logic                           flush,
  input  logic                           wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0]      wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_pc,
  output logic [DATA_WIDTH-1:0]          out_rs1_data,
  output logic [DATA_WIDTH-1:0]          out_rs2_data,
  output logic [DATA_WIDTH-1:0]          out_imm,
  output logic                           out_rd_wen,
  output logic [REG_ADDR_WIDTH-1:0]      out_rd_addr,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_is_halt,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs1Addr;
    logic [REG_ADDR_WIDTH-1:0] rs2Addr;
    logic [DATA_WIDTH-1:0]     rs1Data;
    logic [DATA_WIDTH-1:0]     rs2Data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      rdWen;
    logic [REG_ADDR_WIDTH-1:0] rdAddr;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic                      isHalt;
  } entry_t;

  entry_t                entryMem [DEPTH];
  logic [DEPTH-1:0]      entryValid;
  logic [PtrW-1:0]       rdPtr;
  logic [PtrW-1:0]       wrPtr;
  logic                  enq;
  logic                  deq;
  entry_t                newEntry;
  logic [DATA_WIDTH-1:0] inRs1Byp;
  logic [DATA_WIDTH-1:0] inRs2Byp;
  logic [DATA_WIDTH-1:0] resRs1Byp [DEPTH];
  logic [DATA_WIDTH-1:0] resRs2Byp [DEPTH];

  // Handshakes; flush blocks both sides in its cycle.
  assign in_ready  = (count != CntW'(DEPTH)) && !halted && !flush;
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready && !flush;

  // Forwarding into the incoming operands.
  decode_issue_buffer_operand_bypass #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) uInRs1Byp (
    .wbWen       (wb_wen),
    .wbAddr      (wb_addr),
    .wbData      (wb_data),
    .rsAddr      (in_rs1_addr),
    .rsData      (in_rs1_data),
    .bypassData_c(inRs1Byp)
  );

  decode_issue_buffer_operand_bypass #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) uInRs2Byp (
    .wbWen       (wb_wen),
    .wbAddr      (wb_addr),
    .wbData      (wb_data),
    .rsAddr      (in_rs2_addr),
    .rsData      (in_rs2_data),
    .bypassData_c(inRs2Byp)
  );

  // Forwarding into every resident entry, rs1 and rs2 independently.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : gResident
    decode_issue_buffer_operand_bypass #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) uRs1Byp (
      .wbWen       (wb_wen && entryValid[i]),
      .wbAddr      (wb_addr),
      .wbData      (wb_data),
      .rsAddr      (entryMem[i].rs1Addr),
      .rsData      (entryMem[i].rs1Data),
      .bypassData_c(resRs1Byp[i])
    );

    decode_issue_buffer_operand_bypass #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) uRs2Byp (
      .wbWen       (wb_wen && entryValid[i]),
      .wbAddr      (wb_addr),
      .wbData      (wb_data),
      .rsAddr      (entryMem[i].rs2Addr),
      .rsData      (entryMem[i].rs2Data),
      .bypassData_c(resRs2Byp[i])
    );
  end

  // Incoming record with its operands already forwarded.
  always_comb begin
    newEntry         = '0;
    newEntry.pc      = in_pc;
    newEntry.rs1Addr = in_rs1_addr;
    newEntry.rs2Addr = in_rs2_addr;
    newEntry.rs1Data = inRs1Byp;
    newEntry.rs2Data = inRs2Byp;
    newEntry.imm     = in_imm;
    newEntry.rdWen   = in_rd_wen;
    newEntry.rdAddr  = in_rd_addr;
    newEntry.ctrl    = in_ctrl;
    newEntry.isHalt  = in_is_halt;
  end

  // Entry storage; payload needs no reset since out_* is gated by out_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (enq && (wrPtr == PtrW'(i))) begin
        entryMem[i] <= newEntry;
      end else begin
        entryMem[i].rs1Data <= resRs1Byp[i];
        entryMem[i].rs2Data <= resRs2Byp[i];
      end
    end
  end

  // Pointers, occupancy, valid bits and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
      halted     <= 1'b0;
    end else if (flush) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
      halted     <= 1'b0;
    end else begin
      if (enq) begin
        wrPtr             <= wrPtr + PtrW'(1);
        entryValid[wrPtr] <= 1'b1;
        if (in_is_halt) begin
          halted <= 1'b1;
        end
      end
      if (deq) begin
        rdPtr             <= rdPtr + PtrW'(1);
        entryValid[rdPtr] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry presented combinationally; NOP when empty.
  always_comb begin
    out_pc       = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    out_imm      = '0;
    out_rd_wen   = 1'b0;
    out_rd_addr  = '0;
    out_ctrl     = '0;
    out_is_halt  = 1'b0;
    if (out_valid) begin
      out_pc       = entryMem[rdPtr].pc;
      out_rs1_data = entryMem[rdPtr].rs1Data;
      out_rs2_data = entryMem[rdPtr].rs2Data;
      out_imm      = entryMem[rdPtr].imm;
      out_rd_wen   = entryMem[rdPtr].rdWen;
      out_rd_addr  = entryMem[rdPtr].rdAddr;
      out_ctrl     = entryMem[rdPtr].ctrl;
      out_is_halt  = entryMem[rdPtr].isHalt;
    end
  end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed bench for decode_issue_buffer (default parameters, DEPTH = 2).
module tb_decode_issue_buffer;
  import decode_issue_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_rd_wen;
  logic [4:0]  in_rd_addr;
  logic [15:0] in_ctrl;
  logic        in_is_halt;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic        out_rd_wen;
  logic [4:0]  out_rd_addr;
  logic [15:0] out_ctrl;
  logic        out_is_halt;
  logic [1:0]  count;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd_wen(in_rd_wen), .in_rd_addr(in_rd_addr),
    .in_ctrl(in_ctrl), .in_is_halt(in_is_halt), .flush(flush),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd_wen(out_rd_wen), .out_rd_addr(out_rd_addr),
    .out_ctrl(out_ctrl), .out_is_halt(out_is_halt),
    .count(count), .halted(halted)
  );

  typedef struct {
    logic        inValid;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic        wbWen;
    logic [4:0]  wbA;
    logic [31:0] wbD;
    logic        outReady;
    logic [15:0] ctrl;
    logic        expReady;   // in_ready before the edge
    logic        expValid;   // the rest: after the edge
    logic [1:0]  expCount;
    logic [31:0] expPc;
    logic [31:0] expRs1;
    logic [31:0] expRs2;
    logic [15:0] expCtrl;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(
    logic iv, logic [31:0] pc, logic [4:0] r1a, logic [31:0] r1d,
    logic [4:0] r2a, logic [31:0] r2d, logic ww, logic [4:0] wa,
    logic [31:0] wd, logic orr, logic [15:0] ct, logic er, logic ev,
    logic [1:0] ec, logic [31:0] ep, logic [31:0] e1, logic [31:0] e2,
    logic [15:0] ectl);
    vec_t v;
    v.inValid = iv;  v.pc = pc;  v.rs1a = r1a; v.rs1d = r1d;
    v.rs2a = r2a;    v.rs2d = r2d; v.wbWen = ww; v.wbA = wa; v.wbD = wd;
    v.outReady = orr; v.ctrl = ct; v.expReady = er; v.expValid = ev;
    v.expCount = ec; v.expPc = ep; v.expRs1 = e1; v.expRs2 = e2;
    v.expCtrl = ectl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_rd_wen = 0;
    in_rd_addr = '0; in_ctrl = '0; in_is_halt = 0; flush = 0;
    wb_wen = 0; wb_addr = '0; wb_data = '0; out_ready = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    in_valid = 1; in_pc = 32'h300; in_rd_wen = 1;

    // Reset with an instruction offered.
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_wen", 32'(out_rd_wen), 0);
    idle();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    chk("rst_count_after", 32'(count), 0);
    chk("rst_halted", 32'(halted), 0);

    //            iv pc       r1a r1d      r2a r2d       ww wa wd      or ctrl     er ev ec pc       rs1      rs2       ctrl
    vecs[0] = mk(1, 32'h100, 5, 32'h11,   7, 32'h22,   1, 5, 32'hAA, 0, 16'h11, 1, 1, 1, 32'h100, 32'hAA,   32'h22,   16'h11);
    vecs[1] = mk(1, 32'h104, 3, 32'h33,   0, 32'h0,    1, 7, 32'h55, 0, 16'h22, 1, 1, 2, 32'h100, 32'hAA,   32'h55,   16'h11);
    vecs[2] = mk(1, 32'h108, 7, 32'h66,   7, 32'h66,   1, 0, 32'h99, 0, 16'h33, 0, 1, 2, 32'h100, 32'hAA,   32'h55,   16'h11);
    vecs[3] = mk(0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 3, 32'h77, 1, 16'h0,  0, 1, 1, 32'h104, 32'h77,   32'h0,    16'h22);
    vecs[4] = mk(1, 32'h10C, 0, 32'h1234, 0, 32'h5678, 1, 0, 32'h99, 1, 16'h44, 1, 1, 1, 32'h10C, 32'h1234, 32'h5678, 16'h44);
    vecs[5] = mk(0, 32'h0,   0, 32'h0,    0, 32'h0,    1, 0, 32'h99, 0, 16'h0,  1, 1, 1, 32'h10C, 32'h1234, 32'h5678, 16'h44);
    vecs[6] = mk(0, 32'h0,   0, 32'h0,    0, 32'h0,    0, 0, 32'h0,  1, 16'h0,  1, 0, 0, 32'h0,   32'h0,    32'h0,    16'h0);

    for (int i = 0; i < 7; i++) begin
      in_valid = vecs[i].inValid; in_pc = vecs[i].pc;
      in_rs1_addr = vecs[i].rs1a; in_rs1_data = vecs[i].rs1d;
      in_rs2_addr = vecs[i].rs2a; in_rs2_data = vecs[i].rs2d;
      in_rd_wen = vecs[i].inValid; in_rd_addr = 5'd1; in_ctrl = vecs[i].ctrl;
      wb_wen = vecs[i].wbWen; wb_addr = vecs[i].wbA; wb_data = vecs[i].wbD;
      out_ready = vecs[i].outReady;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].expCount));
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].expPc);
      chk($sformatf("v%0d_rs1", i), out_rs1_data, vecs[i].expRs1);
      chk($sformatf("v%0d_rs2", i), out_rs2_data, vecs[i].expRs2);
      chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].expCtrl));
      chk($sformatf("v%0d_rd_wen", i), 32'(out_rd_wen), 32'(vecs[i].expValid));
    end

    // Halt: accepted, blocks further input, drains.
    idle();
    in_valid = 1; in_pc = 32'h200; in_is_halt = 1; in_imm = 32'h7F; in_ctrl = 16'h00F0;
    tick();
    in_pc = 32'h204; in_is_halt = 0;
    #1;
    chk("halt_halted", 32'(halted), 1);
    chk("halt_in_ready", 32'(in_ready), 0);
    chk("halt_out_is_halt", 32'(out_is_halt), 1);
    chk("halt_out_pc", out_pc, 32'h200);
    chk("halt_out_imm", out_imm, 32'h7F);
    chk("halt_out_ctrl", 32'(out_ctrl), 32'h00F0);
    tick();
    chk("halt_count_held", 32'(count), 1);
    out_ready = 1;
    tick();
    chk("halt_drained_count", 32'(count), 0);
    chk("halt_drained_valid", 32'(out_valid), 0);
    tick();
    chk("halt_count_stays", 32'(count), 0);
    chk("halt_still_halted", 32'(halted), 1);

    // Flush clears halted, then flush a full queue with enq/deq offered.
    idle();
    flush = 1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 0;
    chk("flush_clears_halted", 32'(halted), 0);
    in_valid = 1; in_pc = 32'h400;
    tick();
    in_pc = 32'h404;
    tick();
    chk("flush_full_count", 32'(count), 2);
    in_pc = 32'h408; out_ready = 1; flush = 1;
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_halted", 32'(halted), 0);
    chk("flush_out_pc", out_pc, 0);
    idle();
    tick();
    chk("flush_after_count", 32'(count), 0);
    chk("flush_after_valid", 32'(out_valid), 0);

    // Reset mid-operation drops queued entries immediately.
    in_valid = 1; in_pc = 32'h500;
    tick();
    in_pc = 32'h504;
    tick();
    chk("midrst_pre_count", 32'(count), 2);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_after_valid", 32'(out_valid), 0);
    chk("midrst_after_pc", out_pc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
